// File: rtl/sync_fifo_if.sv
// sync_fifo_if: producer/consumer bundle for sync_fifo; status ports exist only with SYNC_FIFO_STATUS_EN
interface sync_fifo_if #(
  parameter int DATA_W = 32
`ifdef SYNC_FIFO_STATUS_EN
  , parameter int DEPTH = 4
`endif
);
  logic [DATA_W-1:0] data_i;
  logic              push_i;
  logic              full_o;
  logic [DATA_W-1:0] data_o;
  logic              pop_i;
  logic              empty_o;
`ifdef SYNC_FIFO_STATUS_EN
  logic [$clog2(DEPTH):0] count_o;
  logic                   overflow_o;
  logic                   underflow_o;
  modport master (output data_i, push_i, pop_i, input full_o, data_o, empty_o, count_o, overflow_o, underflow_o);
  modport slave  (input data_i, push_i, pop_i, output full_o, data_o, empty_o, count_o, overflow_o, underflow_o);
`else
  modport master (output data_i, push_i, pop_i, input full_o, data_o, empty_o);
  modport slave  (input data_i, push_i, pop_i, output full_o, data_o, empty_o);
`endif
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FWFT FIFO; SYNC_FIFO_STATUS_EN adds count/overflow/underflow outputs
module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input logic      clk_i,
  input logic      rstn_i,
  sync_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_empty;
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  // flags decode from the registered count so they never glitch
  always_comb begin
    w_empty = r_count == '0;
    w_full  = r_count == FULL_CNT;
    w_pop   = bus.pop_i & ~w_empty;
    w_push  = bus.push_i & (~w_full | bus.pop_i);
  end

  assign bus.empty_o = w_empty;
  assign bus.full_o  = w_full;
  assign bus.data_o  = w_empty ? '0 : r_mem[r_rd_ptr];

  // storage is not reset; pointers make stale words unreachable
  always_ff @(posedge clk_i)
    if (rstn_i && w_push) r_mem[r_wr_ptr] <= bus.data_i;

  // pointers wrap naturally; count tracks occupancy 0..DEPTH
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= w_push ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_count  <= (w_push & ~w_pop) ? r_count + 1'b1 : (~w_push & w_pop) ? r_count - 1'b1 : r_count;
    end
  end

`ifdef SYNC_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  // sticky error flags, cleared only by reset
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow | (bus.push_i & w_full & ~bus.pop_i);
      r_underflow <= r_underflow | (bus.pop_i & w_empty);
    end
  end

  assign bus.count_o     = r_count;
  assign bus.overflow_o  = r_overflow;
  assign bus.underflow_o = r_underflow;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: randomized and directed checks of sync_fifo against a queue model
module tb_sync_fifo;
  localparam int DW = 32;
  localparam int DEPTH = 4;

  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic [DW-1:0] q[$];
  logic m_ov = 1'b0;
  logic m_uf = 1'b0;

  always #5 clk_i = ~clk_i;

`ifdef SYNC_FIFO_STATUS_EN
  sync_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();
`else
  sync_fifo_if #(.DATA_W(DW)) bus ();
`endif

  sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .bus    (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare();
    chk("empty", 64'(bus.empty_o), 64'(q.size() == 0));
    chk("full", 64'(bus.full_o), 64'(q.size() == DEPTH));
    chk("data", 64'(bus.data_o), 64'(q.size() > 0 ? q[0] : '0));
`ifdef SYNC_FIFO_STATUS_EN
    chk("count", 64'(bus.count_o), 64'(q.size()));
    chk("overflow", 64'(bus.overflow_o), 64'(m_ov));
    chk("underflow", 64'(bus.underflow_o), 64'(m_uf));
`endif
  endtask

  task automatic step(input logic ps, input logic pp, input logic [DW-1:0] d);
    logic pop_ok, push_ok;
    bus.push_i = ps;
    bus.pop_i  = pp;
    bus.data_i = d;
    pop_ok  = pp && q.size() > 0;
    push_ok = ps && (q.size() < DEPTH || pop_ok);
    @(posedge clk_i);
    if (!rstn_i) begin
      q.delete();
      m_ov = 1'b0;
      m_uf = 1'b0;
    end else begin
      m_ov = m_ov | (ps && q.size() == DEPTH && !pp);
      m_uf = m_uf | (pp && q.size() == 0);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    @(negedge clk_i);
    compare();
  endtask

  task automatic do_reset();
    rstn_i = 1'b0;
    step(1'b1, 1'b1, 32'hDEAD_BEEF);
    rstn_i = 1'b1;
  endtask

  initial begin
    bus.push_i = 1'b0;
    bus.pop_i  = 1'b0;
    bus.data_i = '0;
    do_reset();
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    chk("rst_data", 64'(bus.data_o), 64'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'hA000_0000 + i);
    chk("fill_full", 64'(bus.full_o), 64'd1);
    chk("fill_head", 64'(bus.data_o), 64'hA000_0000);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, '0);
    chk("drain_empty", 64'(bus.empty_o), 64'd1);
    chk("drain_data", 64'(bus.data_o), 64'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'hA000_0000 + i);
    step(1'b1, 1'b1, 32'hB000_0000);
    chk("simul_head", 64'(bus.data_o), 64'hA000_0001);
    chk("simul_full", 64'(bus.full_o), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b0, 32'hC100_0000);
    for (int i = 1; i <= 10; i++) step(1'b1, 1'b1, 32'hC100_0000 + i);
    step(1'b0, 1'b1, '0);
    chk("wrap_empty", 64'(bus.empty_o), 64'd1);
    step(1'b1, 1'b1, 32'hD000_0001);
    chk("bypass_empty", 64'(bus.empty_o), 64'd0);
    chk("bypass_data", 64'(bus.data_o), 64'hD000_0001);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 32'hE000_0000 + i);
    do_reset();
    chk("midrst_empty", 64'(bus.empty_o), 64'd1);
    step(1'b1, 1'b0, 32'hC000_0000);
    chk("midrst_data", 64'(bus.data_o), 64'hC000_0000);
    for (int i = 0; i < 600; i++) begin
      rstn_i = ($urandom_range(0, 59) != 0);
      step(1'($urandom), 1'($urandom), $urandom);
    end
    rstn_i = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
